// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 keyboard transmitter: frame size,
// FSM state encoding and the odd-parity helper.
package ps2_pkg;

    localparam int FRAME_BITS = 11;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_HIGH = 3'd2,
        ST_LOW  = 3'd3,
        ST_GAP  = 3'd4
    } ps2_state_t;

    // Parity bit that makes the total count of ones (data + parity) odd.
    function automatic logic odd_parity(input logic [7:0] data);
        return ~(^data);
    endfunction

endpackage

// File: rtl/ps2_tx_fifo.sv
// Byte FIFO feeding the PS/2 transmitter; head is peekable and only
// leaves the queue on an explicit pop.
module ps2_tx_fifo #(
    parameter int DEPTH = 8
) (
    input  logic                     clock,
    input  logic                     power,
    input  logic                     i_push,
    input  logic [7:0]               i_data,
    input  logic                     i_pop,
    output logic [7:0]               o_peek,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic [$clog2(DEPTH):0]   o_count_nxt,
    output logic                     o_ready
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_C = (AW+1)'(DEPTH);
    localparam logic [AW:0] ZERO_C = (AW+1)'(0);
    localparam logic [AW:0] ONE_C  = (AW+1)'(1);

    logic [7:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic          r_ready;
    logic          w_push;
    logic          w_pop;
    logic [AW:0]   w_count_nxt;

    // Qualify requests against occupancy and compute the post-edge count.
    always_comb begin
        w_push = i_push && (r_count != FULL_C);
        w_pop  = i_pop && (r_count != ZERO_C);
        case ({w_push, w_pop})
            2'b10:   w_count_nxt = r_count + ONE_C;
            2'b01:   w_count_nxt = r_count - ONE_C;
            default: w_count_nxt = r_count;
        endcase
    end

    // Storage array; contents need no reset because the pointers define validity.
    always_ff @(posedge clock) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    // Pointers, occupancy and the registered ready flag.
    always_ff @(posedge clock or negedge power) begin
        if (!power) begin
            r_wr_ptr <= {AW{1'b0}};
            r_rd_ptr <= {AW{1'b0}};
            r_count  <= ZERO_C;
            r_ready  <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            r_count <= w_count_nxt;
            r_ready <= (w_count_nxt < FULL_C);
        end
    end

    assign o_peek      = r_mem[r_rd_ptr];
    assign o_count     = r_count;
    assign o_count_nxt = w_count_nxt;
    assign o_ready     = r_ready;

endmodule

// File: rtl/ps2_kbd_tx.sv
// Device-side PS/2 keyboard transmitter: FIFO-fed 11-bit frames with an
// inter-frame gap. Define PS2_TX_INHIBIT_EN to honour host clock inhibit.
module ps2_kbd_tx
    import ps2_pkg::*;
#(
    parameter int CLK_DIV = 2500,
    parameter int GAP     = 10000,
    parameter int DEPTH   = 8
) (
    input  logic       clock,
    input  logic       power,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic       ps2_clk_in,
    output logic       ps2_clk,
    output logic       ps2_dat,
    output logic       busy
);

    localparam int TMAX  = (GAP > CLK_DIV) ? GAP : CLK_DIV;
    localparam int CW    = $clog2(TMAX + 1);
    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam logic [3:0] LAST_IDX = 4'(FRAME_BITS - 1);

    ps2_state_t       r_state;
    ps2_state_t       w_state_nxt;
    logic [CW-1:0]    r_tmr;
    logic [CW-1:0]    w_tmr_nxt;
    logic [3:0]       r_idx;
    logic [3:0]       w_idx_nxt;
    logic [3:0]       w_idx_inc;
    logic [10:0]      r_shift;
    logic [10:0]      w_shift_nxt;
    logic             r_clk;
    logic             r_dat;
    logic             r_busy;
    logic             w_clk_nxt;
    logic             w_dat_nxt;
    logic             w_pop;
    logic             w_push;
    logic             w_ready;
    logic [7:0]       w_head;
    logic [CNT_W-1:0] w_count;
    logic [CNT_W-1:0] w_count_nxt;
    logic             w_div_done;
    logic             w_gap_done;
    logic             w_abort;
    logic             w_start_ok;

    assign w_push     = in_valid && w_ready;
    assign w_div_done = (r_tmr == CW'(CLK_DIV - 1));
    assign w_gap_done = (r_tmr == CW'(GAP - 1));
    assign w_idx_inc  = r_idx + 4'd1;

    ps2_tx_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock       (clock),
        .power       (power),
        .i_push      (w_push),
        .i_data      (in_data),
        .i_pop       (w_pop),
        .o_peek      (w_head),
        .o_count     (w_count),
        .o_count_nxt (w_count_nxt),
        .o_ready     (w_ready)
    );

`ifdef PS2_TX_INHIBIT_EN
    logic r_sync1;
    logic r_sync_clk;
    logic r_inh_prev;
    logic w_inh_low;

    // The first two HIGH cycles after LOW still see our own low clock through the synchronizer.
    assign w_inh_low  = (r_state == ST_HIGH) && (r_idx <= 4'd9) && (r_tmr >= CW'(2)) && !r_sync_clk;
    assign w_abort    = w_inh_low && r_inh_prev;
    assign w_start_ok = r_sync_clk;

    // Two-flop synchronizer for the sensed clock line plus the one-cycle inhibit history.
    always_ff @(posedge clock or negedge power) begin
        if (!power) begin
            r_sync1    <= 1'b1;
            r_sync_clk <= 1'b1;
            r_inh_prev <= 1'b0;
        end else begin
            r_sync1    <= ps2_clk_in;
            r_sync_clk <= r_sync1;
            r_inh_prev <= w_inh_low;
        end
    end
`else
    logic w_unused_clk_in;

    assign w_unused_clk_in = ps2_clk_in;
    assign w_abort         = 1'b0;
    assign w_start_ok      = 1'b1;
`endif

    // State register.
    always_ff @(posedge clock or negedge power) begin
        if (!power) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if ((w_count != CNT_W'(0)) && w_start_ok) begin
                    w_state_nxt = ST_LOAD;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_LOAD: w_state_nxt = ST_HIGH;
            ST_HIGH: begin
                if (w_abort) begin
                    w_state_nxt = ST_GAP;
                end else if (w_div_done) begin
                    w_state_nxt = ST_LOW;
                end else begin
                    w_state_nxt = ST_HIGH;
                end
            end
            ST_LOW: begin
                if (!w_div_done) begin
                    w_state_nxt = ST_LOW;
                end else if (r_idx < LAST_IDX) begin
                    w_state_nxt = ST_HIGH;
                end else begin
                    w_state_nxt = ST_GAP;
                end
            end
            ST_GAP: begin
                if (w_gap_done) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_GAP;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Output/datapath next values; the head is popped only once the stop bit completes.
    always_comb begin
        w_clk_nxt   = 1'b1;
        w_dat_nxt   = 1'b1;
        w_tmr_nxt   = {CW{1'b0}};
        w_idx_nxt   = r_idx;
        w_shift_nxt = r_shift;
        w_pop       = 1'b0;
        case (r_state)
            ST_IDLE: w_idx_nxt = 4'd0;
            ST_LOAD: begin
                w_shift_nxt = {1'b1, odd_parity(w_head), w_head, 1'b0};
                w_dat_nxt   = 1'b0;
                w_idx_nxt   = 4'd0;
            end
            ST_HIGH: begin
                if (w_abort) begin
                    w_idx_nxt = 4'd0;
                end else if (w_div_done) begin
                    w_clk_nxt = 1'b0;
                    w_dat_nxt = r_dat;
                end else begin
                    w_dat_nxt = r_dat;
                    w_tmr_nxt = r_tmr + CW'(1);
                end
            end
            ST_LOW: begin
                if (!w_div_done) begin
                    w_clk_nxt = 1'b0;
                    w_dat_nxt = r_dat;
                    w_tmr_nxt = r_tmr + CW'(1);
                end else if (r_idx < LAST_IDX) begin
                    w_idx_nxt = w_idx_inc;
                    w_dat_nxt = r_shift[w_idx_inc];
                end else begin
                    w_pop     = 1'b1;
                    w_idx_nxt = 4'd0;
                end
            end
            ST_GAP: begin
                if (w_gap_done) begin
                    w_tmr_nxt = {CW{1'b0}};
                end else begin
                    w_tmr_nxt = r_tmr + CW'(1);
                end
            end
            default: w_idx_nxt = 4'd0;
        endcase
    end

    // Registered line drivers, counters and busy flag.
    always_ff @(posedge clock or negedge power) begin
        if (!power) begin
            r_clk   <= 1'b1;
            r_dat   <= 1'b1;
            r_tmr   <= {CW{1'b0}};
            r_idx   <= 4'd0;
            r_shift <= 11'h7FF;
            r_busy  <= 1'b0;
        end else begin
            r_clk   <= w_clk_nxt;
            r_dat   <= w_dat_nxt;
            r_tmr   <= w_tmr_nxt;
            r_idx   <= w_idx_nxt;
            r_shift <= w_shift_nxt;
            r_busy  <= (w_state_nxt != ST_IDLE) || (w_count_nxt != CNT_W'(0));
        end
    end

    assign ps2_clk  = r_clk;
    assign ps2_dat  = r_dat;
    assign busy     = r_busy;
    assign in_ready = w_ready;

endmodule

// File: tb/tb_ps2_kbd_tx.sv
// Self-checking bench for ps2_kbd_tx: a line-level frame decoder feeds a
// byte scoreboard; directed steps cover latency, back-pressure and reset.
module tb_ps2_kbd_tx;

    localparam int CLK_DIV = 4;
    localparam int GAP     = 16;
    localparam int DEPTH   = 8;

    logic       clock = 1'b0;
    logic       power = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       in_valid = 1'b0;
    logic       ps2_clk_in = 1'b1;
    logic       in_ready;
    logic       ps2_clk;
    logic       ps2_dat;
    logic       busy;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int acc_cyc = 0;

    logic [7:0] exp_q[$];
    logic [7:0] rcv_q[$];

    int          bitn = 0;
    int          fall_total = 0;
    int          aborts = 0;
    int          first_fall = 0;
    int          last_rise = 0;
    int          hi_cnt = 0;
    bit          pending_rise = 1'b0;
    bit          rise_valid = 1'b0;
    logic        prev_clk = 1'b1;
    logic        prev_dat = 1'b1;
    logic [10:0] frame_bits = 11'h000;
    logic [10:0] last_frame = 11'h000;

    ps2_kbd_tx #(
        .CLK_DIV (CLK_DIV),
        .GAP     (GAP),
        .DEPTH   (DEPTH)
    ) dut (
        .clock      (clock),
        .power      (power),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .ps2_clk_in (ps2_clk_in),
        .ps2_clk    (ps2_clk),
        .ps2_dat    (ps2_dat),
        .busy       (busy)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc = cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks = checks + 1;
        assert (obs === expv) else begin
            failures = failures + 1;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    // Receiver model: decode frames on falling ps2_clk, drop partial frames after a long high.
    always @(negedge clock) begin
        if (!power) begin
            bitn = 0;
            pending_rise = 1'b0;
            rise_valid = 1'b0;
            hi_cnt = 0;
        end else begin
            if (ps2_dat !== prev_dat) check("dat_changes_while_clk_high", 32'(ps2_clk), 32'd1);
            if (prev_clk && !ps2_clk) begin
                if (bitn == 0) begin
                    first_fall = cyc;
                    if (rise_valid) check("interframe_gap_ge_GAP", 32'(((cyc - CLK_DIV) - last_rise) >= GAP), 32'd1);
                end
                frame_bits[4'(bitn)] = ps2_dat;
                bitn = bitn + 1;
                fall_total = fall_total + 1;
                if (bitn == 11) begin
                    check("start_bit", 32'(frame_bits[0]), 32'd0);
                    check("stop_bit", 32'(frame_bits[10]), 32'd1);
                    check("odd_parity", 32'($countones(frame_bits[9:1]) % 2), 32'd1);
                    rcv_q.push_back(frame_bits[8:1]);
                    last_frame = frame_bits;
                    bitn = 0;
                    pending_rise = 1'b1;
                end
            end
            if (!prev_clk && ps2_clk && pending_rise) begin
                last_rise = cyc;
                pending_rise = 1'b0;
                rise_valid = 1'b1;
                check("frame_length", 32'(cyc - (first_fall - CLK_DIV)), 32'(22 * CLK_DIV));
            end
            if (ps2_clk) hi_cnt = hi_cnt + 1;
            else hi_cnt = 0;
            if ((hi_cnt >= 3 * CLK_DIV) && (bitn != 0)) begin
                aborts = aborts + 1;
                bitn = 0;
            end
        end
        prev_clk = ps2_clk;
        prev_dat = ps2_dat;
    end

    // Offer a byte (in_valid left high) and wait for the accepting edge.
    task automatic push_byte(input logic [7:0] b);
        logic rdy;
        rdy = 1'b0;
        in_data = b;
        in_valid = 1'b1;
        for (int k = 0; k < 1000; k++) begin
            rdy = in_ready;
            @(posedge clock);
            #1;
            if (rdy) break;
        end
        check("push_accept_timeout", 32'(rdy), 32'd1);
        if (rdy) begin
            exp_q.push_back(b);
            acc_cyc = cyc;
        end
    endtask

    task automatic wait_idle(input int max_cyc);
        for (int k = 0; k < max_cyc; k++) begin
            @(posedge clock);
            #1;
            if (!busy) break;
        end
        check("wait_idle_timeout", 32'(busy), 32'd0);
    endtask

    task automatic wait_bits(input int n);
        for (int k = 0; k < 400; k++) begin
            if (bitn >= n) break;
            @(posedge clock);
            #1;
        end
        check("wait_bits_timeout", 32'(bitn >= n), 32'd1);
    endtask

    task automatic compare_queues(input string tag);
        check({tag, "_frame_count"}, 32'(rcv_q.size()), 32'(exp_q.size()));
        for (int i = 0; (i < exp_q.size()) && (i < rcv_q.size()); i++) begin
            check({tag, "_byte"}, 32'(rcv_q[i]), 32'(exp_q[i]));
        end
        rcv_q.delete();
        exp_q.delete();
    endtask

    initial begin
        int f0;
        int n;
        int gaps;
        logic [7:0] b;

        // Reset state
        repeat (3) @(posedge clock);
        #1;
        check("reset_ps2_clk", 32'(ps2_clk), 32'd1);
        check("reset_ps2_dat", 32'(ps2_dat), 32'd1);
        check("reset_in_ready", 32'(in_ready), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        power = 1'b1;
        @(posedge clock);
        #1;
        check("in_ready_after_release", 32'(in_ready), 32'd1);

        // Single byte 0x1C: latency, bit pattern, frame length, gap to idle
        push_byte(8'h1C);
        in_valid = 1'b0;
        n = acc_cyc;
        @(posedge clock);
        #1;
        check("dat_high_at_N+1", 32'(ps2_dat), 32'd1);
        @(posedge clock);
        #1;
        check("start_bit_at_N+2", 32'(ps2_dat), 32'd0);
        check("clk_high_at_N+2", 32'(ps2_clk), 32'd1);
        wait_idle(400);
        check("first_fall_latency", 32'(first_fall - n), 32'(2 + CLK_DIV));
        check("frame_1C_bits", 32'(last_frame), 32'({1'b1, 1'b0, 8'h1C, 1'b0}));
        check("busy_drop_after_gap", 32'(cyc - last_rise), 32'(GAP));
        compare_queues("single_1C");

        // Back-to-back 0xF0, 0x00
        push_byte(8'hF0);
        push_byte(8'h00);
        in_valid = 1'b0;
        wait_idle(600);
        check("parity_00", 32'(last_frame[9]), 32'd1);
        compare_queues("b2b");

        // Nine bytes with in_valid held: FIFO fills, ninth waits for the first pop
        for (int i = 0; i < 9; i++) begin
            push_byte(8'(8'h31 + 8'(i * 7)));
            if (i == 7) check("in_ready_low_when_full", 32'(in_ready), 32'd0);
            if (i == 8) check("ninth_accept_after_first_stop", 32'(acc_cyc), 32'(last_rise + 1));
        end
        in_valid = 1'b0;
        wait_idle(3000);
        compare_queues("fill9");

        // Reset during bit 5 of 0xAA
        push_byte(8'hAA);
        in_valid = 1'b0;
        wait_bits(6);
        check("clk_low_in_bit5", 32'(ps2_clk), 32'd0);
        #2;
        power = 1'b0;
        #1;
        check("async_reset_clk", 32'(ps2_clk), 32'd1);
        check("async_reset_dat", 32'(ps2_dat), 32'd1);
        check("async_reset_in_ready", 32'(in_ready), 32'd0);
        check("async_reset_busy", 32'(busy), 32'd0);
        exp_q.delete();
        rcv_q.delete();
        repeat (3) @(posedge clock);
        #1;
        power = 1'b1;
        f0 = fall_total;
        @(posedge clock);
        #1;
        check("in_ready_after_rerelease", 32'(in_ready), 32'd1);
        repeat (150) @(posedge clock);
        #1;
        check("no_residual_frame", 32'(fall_total - f0), 32'd0);
        check("idle_after_reset", 32'(busy), 32'd0);

        // Host pulls ps2_clk_in low mid-HIGH of bit 4 of 0x55
        push_byte(8'h55);
        in_valid = 1'b0;
        wait_bits(4);
        for (int k = 0; k < 50; k++) begin
            if (ps2_clk) break;
            @(posedge clock);
            #1;
        end
        ps2_clk_in = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        ps2_clk_in = 1'b1;
        wait_idle(800);
`ifdef PS2_TX_INHIBIT_EN
        check("inhibit_abort_count", 32'(aborts), 32'd1);
`else
        check("no_abort_without_inhibit", 32'(aborts), 32'd0);
`endif
        compare_queues("inhibit_55");

`ifdef PS2_TX_INHIBIT_EN
        // Inhibit held at idle: no start bit until released
        ps2_clk_in = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        f0 = fall_total;
        push_byte(8'h3C);
        in_valid = 1'b0;
        repeat (40) @(posedge clock);
        #1;
        check("idle_inhibit_dat_high", 32'(ps2_dat), 32'd1);
        check("idle_inhibit_no_falls", 32'(fall_total - f0), 32'd0);
        check("idle_inhibit_busy", 32'(busy), 32'd1);
        ps2_clk_in = 1'b1;
        wait_idle(600);
        compare_queues("idle_inhibit");
`endif

        // Randomized byte stream with random valid gaps
        for (int i = 0; i < 24; i++) begin
            b = 8'($urandom);
            push_byte(b);
            in_valid = 1'b0;
            gaps = int'($urandom_range(0, 3));
            for (int j = 0; j < gaps; j++) begin
                @(posedge clock);
                #1;
            end
        end
        wait_idle(6000);
        compare_queues("random");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
